// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, the counterpart of the full-adder cell.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  // difference bit and borrow-out of a - b - borrow_in
  always_comb begin
    diff       = a ^ b ^ borrow_in;
    borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = a - b, LSB first, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start, last result held on d/borrow
// RUN   | one bit per edge through the full-subtractor cell
// DONE  | done pulse, result valid; start here re-arms back-to-back
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         borrow
);

  localparam int               CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  sub_state_t       state_q;
  logic [N-1:0]     a_sr_q;
  logic [N-1:0]     b_sr_q;
  logic [N-1:0]     d_q;
  logic [N-1:0]     d_d;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic             diff_bit;
  logic             bout_bit;

  full_subtractor u_fs (
    .a          (a_sr_q[0]),
    .b          (b_sr_q[0]),
    .borrow_in  (borrow_q),
    .diff       (diff_bit),
    .borrow_out (bout_bit)
  );

  // new difference bit enters at the MSB so bit 0 ends at d[0] after N shifts
  assign d_d = {diff_bit, d_q[N-1:1]};

  // sequencing FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          d_q      <= d_d;
          borrow_q <= bout_bit;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign d      = d_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and small randomized checks of serial_subtractor at N=4 and N=8.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start4;
  logic [3:0] a4, b4, d4;
  logic       busy4, done4, borrow4;

  logic       start8;
  logic [7:0] a8, b8, d8;
  logic       busy8, done8, borrow8;

  int checks;
  int failures;

  serial_subtractor #(.N(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .d      (d4),
    .borrow (borrow4)
  );

  serial_subtractor #(.N(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .d      (d8),
    .borrow (borrow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Runs one N=4 operation from a negedge; pulse_at >= 0 injects an
  // ignored start (a=1, b=2) at that RUN cycle index.
  task automatic run4(input logic [3:0] av, input logic [3:0] bv,
                      input logic [3:0] exp_d, input logic exp_b,
                      input int pulse_at, input string tag);
    int k;
    int nbusy;
    k     = 0;
    nbusy = 0;
    start4 = 1'b1;
    a4     = av;
    b4     = bv;
    @(negedge clk);
    start4 = 1'b0;
    while (!done4 && k < 20) begin
      if (busy4) nbusy++;
      if (k == pulse_at) begin
        start4 = 1'b1;
        a4     = 4'd1;
        b4     = 4'd2;
      end else begin
        start4 = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    start4 = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(done4), 32'd1);
    check_eq({tag, "_latency"}, 32'(k), 32'd4);
    check_eq({tag, "_busy_cycles"}, 32'(nbusy), 32'd4);
    check_eq({tag, "_busy_at_done"}, 32'(busy4), 32'd0);
    check_eq({tag, "_d"}, 32'(d4), 32'(exp_d));
    check_eq({tag, "_borrow"}, 32'(borrow4), 32'(exp_b));
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, 32'(done4), 32'd0);
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, 32'(busy4), 32'd0);
    check_eq({tag, "_d_held"}, 32'(d4), 32'(exp_d));
    check_eq({tag, "_borrow_held"}, 32'(borrow4), 32'(exp_b));
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input string tag);
    int k;
    logic [7:0] exp_d;
    logic       exp_b;
    exp_d = av - bv;
    exp_b = (av < bv);
    k      = 0;
    start8 = 1'b1;
    a8     = av;
    b8     = bv;
    @(negedge clk);
    start8 = 1'b0;
    while (!done8 && k < 30) begin
      k++;
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, 32'(k), 32'd8);
    check_eq({tag, "_d"}, 32'(d8), 32'(exp_d));
    check_eq({tag, "_borrow"}, 32'(borrow8), 32'(exp_b));
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n  = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;

    #3;
    check_eq("rst_busy", 32'(busy4), 32'd0);
    check_eq("rst_done", 32'(done4), 32'd0);
    check_eq("rst_d", 32'(d4), 32'd0);
    check_eq("rst_borrow", 32'(borrow4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run4(4'd9,  4'd3,  4'd6,  1'b0, -1, "9m3");
    run4(4'd3,  4'd9,  4'd10, 1'b1, -1, "3m9");
    run4(4'd0,  4'd1,  4'd15, 1'b1, -1, "0m1");
    run4(4'd15, 4'd15, 4'd0,  1'b0, -1, "15m15");
    run4(4'd0,  4'd0,  4'd0,  1'b0, -1, "0m0");
    run4(4'd9,  4'd3,  4'd6,  1'b0, 1,  "ign_start");

    // start held high: one result every 5 cycles, busy low only on done
    start4 = 1'b1;
    a4     = 4'd5;
    b4     = 4'd7;
    @(negedge clk);
    for (int k = 0; k < 15; k++) begin
      check_eq($sformatf("b2b_busy_%0d", k), 32'(busy4), 32'((k % 5) != 4));
      check_eq($sformatf("b2b_done_%0d", k), 32'(done4), 32'((k % 5) == 4));
      if ((k % 5) == 4) begin
        check_eq($sformatf("b2b_d_%0d", k), 32'(d4), 32'd14);
        check_eq($sformatf("b2b_borrow_%0d", k), 32'(borrow4), 32'd1);
      end
      if (k == 14) start4 = 1'b0;
      @(negedge clk);
    end
    check_eq("b2b_stop_busy", 32'(busy4), 32'd0);
    check_eq("b2b_stop_done", 32'(done4), 32'd0);
    check_eq("b2b_stop_d", 32'(d4), 32'd14);

    // asynchronous reset in the middle of RUN
    start4 = 1'b1;
    a4     = 4'd9;
    b4     = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    check_eq("mid_busy_pre", 32'(busy4), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy4), 32'd0);
    check_eq("mid_rst_done", 32'(done4), 32'd0);
    check_eq("mid_rst_d", 32'(d4), 32'd0);
    check_eq("mid_rst_borrow", 32'(borrow4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run4(4'd8, 4'd8, 4'd0, 1'b0, -1, "8m8");

    // N=8 corners plus a short random sweep
    run8(8'd0,   8'd255, "n8_0m255");
    run8(8'd255, 8'd0,   "n8_255m0");
    run8(8'd128, 8'd127, "n8_128m127");
    for (int i = 0; i < 16; i++) begin
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $sformatf("n8_rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
